// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Ports: clk, reset (sync, active-high); req_valid/req_data/req_ready per
// requester; tx_start/tx_data/tx_busy to the transmitter; grant_id, active,
// timeout_err for status.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int ACK_TIMEOUT  = 16,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] DONE_LAST = 16'(11 * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt;
  logic [IW-1:0] grant_nxt;
  logic [7:0]    data_nxt;
  logic [15:0]   cnt, cnt_nxt, cnt_inc;
  logic [IW-1:0] winner, cand;
  logic          found;

  // First valid index at or after last_grant+1, wrapping.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Watchdog saturates instead of wrapping.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    last_nxt    = last_grant;
    data_nxt    = tx_data;
    cnt_nxt     = cnt;
    req_ready   = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          grant_nxt = winner;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[grant_id]) begin
          req_ready[grant_id] = 1'b1;
          data_nxt  = req_data[{grant_id, 3'b000} +: 8];
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        tx_start  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_DONE;
        end else if (cnt >= ACK_LAST) begin
          timeout_err = 1'b1;
          last_nxt    = grant_id;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          last_nxt  = grant_id;
          state_nxt = IDLE;
        end else if (cnt >= DONE_LAST) begin
          timeout_err = 1'b1;
          last_nxt    = grant_id;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      tx_data    <= 8'h00;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      tx_data    <= data_nxt;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Drives requesters and models the transmitter busy flag by hand.
module tb_uart_tx_arbiter;

  localparam int F      = 100;
  localparam int F_FULL = 9548;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int checks;
  int errors;
  int cyc;
  int to_cnt;
  int multi_ready;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .CLKS_PER_BIT(868),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_err === 1'b1) to_cnt++;
    if (!$onehot0(req_ready)) multi_ready++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int lim, output int at);
    int i;
    i = 0;
    while (tx_start !== 1'b1 && i < lim) begin
      tick(1);
      i++;
    end
    chk("start_seen", 32'(tx_start), 1);
    at = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_start"}, 32'(tx_start), 0);
    chk({tag, "_data"}, 32'(tx_data), 0);
    chk({tag, "_grant"}, 32'(grant_id), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_tout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int s;
    int prev;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    to_cnt      = 0;
    multi_ready = 0;
    reset       = 1'b1;
    req_valid   = '0;
    req_data    = 32'h44_43_42_41;
    tx_busy     = 1'b0;
    prev        = 0;

    // Reset state
    tick(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick(1);

    // Round-robin under full load: 0,1,2,3,0
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_start(20, s);
      chk("rr_grant", 32'(grant_id), 32'(k % 4));
      chk("rr_data", 32'(tx_data), 32'(8'h41 + (k % 4)));
      if (k > 0) chk("rr_gap", 32'(s - prev), 32'(F + 4));
      prev = s;
      if (k == 4) req_valid = '0;
      tick(1);
      tx_busy = 1'b1;
      tick(F);
      tx_busy = 1'b0;
    end
    tick(1);
    chk("rr_idle", 32'(active), 0);

    // Single request on index 2
    req_data  = 32'h44_41_42_11;
    req_valid = 4'b0100;
    tick(1);
    chk("one_ready", 32'(req_ready), 4);
    chk("one_active", 32'(active), 1);
    chk("one_grant", 32'(grant_id), 2);
    tick(1);
    chk("one_start", 32'(tx_start), 1);
    chk("one_data", 32'(tx_data), 8'h41);
    req_valid = '0;
    tick(1);
    chk("one_start_pulse", 32'(tx_start), 0);
    tx_busy = 1'b1;
    tick(F_FULL);
    tx_busy = 1'b0;
    chk("one_busy_active", 32'(active), 1);
    tick(1);
    chk("one_done", 32'(active), 0);
    chk("one_done_grant", 32'(grant_id), 2);
    chk("one_no_tout", 32'(to_cnt), 0);

    // Ack timeout, then next index
    req_valid = 4'b0110;
    wait_start(10, s);
    chk("ack_grant", 32'(grant_id), 1);
    tick(15);
    chk("ack_tout_early", 32'(timeout_err), 0);
    tick(1);
    chk("ack_tout", 32'(timeout_err), 1);
    tick(1);
    chk("ack_idle", 32'(active), 0);
    tick(1);
    chk("ack_next_grant", 32'(grant_id), 2);
    chk("ack_next_ready", 32'(req_ready), 4);

    // Frame timeout with busy stuck high
    tick(1);
    chk("fr_start", 32'(tx_start), 1);
    req_valid = '0;
    tick(1);
    tx_busy = 1'b1;
    tick(9547);
    chk("fr_tout_early", 32'(timeout_err), 0);
    tick(1);
    chk("fr_tout", 32'(timeout_err), 1);
    tick(1);
    chk("fr_idle", 32'(active), 0);

    // Busy in IDLE blocks grants without timeout
    req_valid = 4'b0001;
    tick(3);
    chk("busy_block", 32'(active), 0);
    chk("busy_no_tout", 32'(to_cnt), 2);
    tx_busy = 1'b0;
    tick(1);
    chk("busy_rel_ready", 32'(req_ready), 1);

    // Reset in WAIT_DONE
    tick(2);
    tx_busy = 1'b1;
    tick(4);
    chk("mid_active", 32'(active), 1);
    reset     = 1'b1;
    req_valid = '0;
    tick(1);
    chk_reset_vals("mid");
    reset     = 1'b0;
    tx_busy   = 1'b0;
    req_valid = 4'hF;
    tick(1);
    chk("post_rst_grant", 32'(grant_id), 0);
    chk("post_rst_ready", 32'(req_ready), 1);
    req_valid = '0;
    #1;
    chk("wd0_ready", 32'(req_ready), 0);
    tick(1);
    chk("wd0_idle", 32'(active), 0);

    // Withdrawn request on index 1
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    #1;
    chk("wd1_ready", 32'(req_ready), 0);
    tick(1);
    chk("wd1_start", 32'(tx_start), 0);
    chk("wd1_idle", 32'(active), 0);
    chk("wd1_data", 32'(tx_data), 0);
    req_valid = 4'b0110;
    tick(1);
    chk("wd1_regrant", 32'(grant_id), 1);
    chk("wd1_reready", 32'(req_ready), 2);
    tick(1);
    chk("wd1_restart", 32'(tx_start), 1);
    chk("wd1_redata", 32'(tx_data), 8'h42);
    req_valid = '0;
    tick(17);
    chk("end_idle", 32'(active), 0);
    chk("end_tout_cnt", 32'(to_cnt), 3);
    chk("ready_onehot", 32'(multi_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between up to NUM_REQ byte sources using round-robin arbitration. Each source offers a byte through a valid/ready handshake. The block sequences the transmitter with a one-cycle start pulse, then holds off the next grant until the transmitter's busy flag clears. Watchdog timers recover from a transmitter that never acknowledges or never finishes. It sits between the command/status logic and the UART transmitter, which runs at the same baud setting as the UART receiver (868 clocks/bit at 100 MHz, 115200 baud).

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CLKS_PER_BIT, 868: clocks per UART bit; 11*CLKS_PER_BIT must be < 65536.
- ACK_TIMEOUT, 16: maximum clocks from tx_start to tx_busy rising.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse; the byte transfers when ready and valid are both high.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte to transmit; stable from tx_start until return to IDLE.
- tx_busy  in  1  transmitter busy (frame in progress).
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- active  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States are IDLE, LOAD, START, WAIT_ACK and WAIT_DONE. The state register is 3 bits.
- **IDLE**
  - Grant only if some req_valid=1 and tx_busy=0.
  - The winner is the first asserted index searching upward from (last_grant+1) mod NUM_REQ, with wrap.
  - Register the winner into grant_id, then go to LOAD.
- **LOAD**
  - If req_valid[grant_id]=1: assert req_ready[grant_id], capture its req_data slice into tx_data, go to START.
  - If the request was withdrawn: no ready, tx_data and last_grant unchanged, go to IDLE.
- **START**
  - tx_start=1 for exactly this cycle. Clear the 16-bit watchdog counter. Go to WAIT_ACK.
- **WAIT_ACK**
  - If tx_busy=1: clear the counter, go to WAIT_DONE.
  - Otherwise increment the counter. When counter reaches ACK_TIMEOUT-1 with tx_busy still 0: pulse timeout_err, go to IDLE.
- **WAIT_DONE**
  - If tx_busy=0: last_grant<=grant_id, go to IDLE.
  - Otherwise increment the counter. When it reaches 11*CLKS_PER_BIT-1: pulse timeout_err, set last_grant<=grant_id, go to IDLE.
- After a timeout, last_grant is updated so a faulty requester cannot starve the others.
- The watchdog counter saturates and never wraps.
- Only one req_ready bit is ever high. req_ready never asserts outside LOAD.

## Timing
- **Reset values:** req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, timeout_err=0, state=IDLE.
- **Reset priority:** last_grant resets to NUM_REQ-1, so requester 0 wins first. Reset asserted in any state returns to IDLE on the next edge with all outputs at reset values. Any frame in flight is abandoned with no timeout_err.
- **Latency:** req_valid seen in IDLE at cycle 0 gives req_ready at cycle 1 and tx_start at cycle 2. active rises at cycle 1.
- **Back-to-back grants:** tx_busy falling in WAIT_DONE at cycle n returns the FSM to IDLE at n+1. A pending request gets req_ready at n+2. Minimum gap between tx_start pulses is frame length + 4 cycles.
- **Busy at IDLE:** tx_busy=1 in IDLE (foreign or residual frame) blocks granting, with no timeout.
- **Simultaneous requests:** resolved only by round-robin order.
- **Requester rules:** req_valid may rise in any cycle. Requesters hold req_data stable while valid until the ready cycle.

## Test plan
- **Single request:** req_valid[2]=1 with data 8'h41 at cycle 0 → req_ready=4'b0100 at cycle 1, tx_start with tx_data=8'h41 at cycle 2. Model busy for 9548 cycles → active falls and grant_id=2.
- **Round-robin under full load:** all four valid continuously, bytes 8'h41, 8'h42, 8'h43, 8'h44 → grants in order 0,1,2,3,0. No two req_ready pulses occur less than one frame apart.
- **Ack timeout:** tx_busy held 0 after tx_start → timeout_err pulses 16 cycles after the tx_start cycle. Next grant goes to the next index, not the same one.
- **Frame timeout:** tx_busy stuck at 1 after ack → timeout_err after 9548 cycles in WAIT_DONE, then FSM returns to IDLE.
- **Reset mid-frame:** assert reset during WAIT_DONE → next edge all outputs at reset values. After release, requester 0 wins first.
- **Withdrawn request:** req_valid[1] pulses for only the IDLE cycle → no req_ready and no tx_start. FSM returns to IDLE; with no other request pending, the next grant goes to index 1 again when re-requested.
